// File: rtl/cpu0_pkg.sv
// Shared encodings and defaults for the cpu0 memory slave: bus size codes,
// controller states and the default memory map.
package cpu0_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_INT16 = 2'b01;
  localparam logic [1:0] SIZE_INT24 = 2'b10;
  localparam logic [1:0] SIZE_INT32 = 2'b11;

  localparam int          MEMSIZE = 28672;
  localparam logic [31:0] IOADDR  = 32'h7000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE:  return 3'd1;
      SIZE_INT16: return 3'd2;
      SIZE_INT24: return 3'd3;
      SIZE_INT32: return 3'd4;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/cpu0_io_fifo.sv
// Synchronous FIFO behind the byte output port. A push into a full FIFO is
// accepted when a pop happens on the same edge; a pop while empty is ignored.
module cpu0_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt_q;
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cpu0_mem_ctrl.sv
// Clocked big-endian byte RAM slave for the cpu0 bus with programmable wait
// states, range errors and a FIFO-backed byte output port at IO_ADDR.
module cpu0_mem_ctrl
  import cpu0_pkg::*;
#(
  parameter int          MEM_BYTES   = MEMSIZE,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] IO_ADDR     = IOADDR,
  parameter int          IO_DEPTH    = 8,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m_en,
  input  logic        m_rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        m_ready,
  output logic        m_err,
  output logic [7:0]  io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int AW  = $clog2(MEM_BYTES);
  localparam int FCW = $clog2(IO_DEPTH) + 1;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] dbus_q;
  logic        ready_q, err_q;

  // Power-up contents; reset deliberately leaves the array alone.
  logic [7:0]  mem_q [MEM_BYTES] = '{default: FILL_BYTE};

  logic [2:0]     nbytes;
  logic [32:0]    last_a;
  logic           is_io, range_err;
  logic [AW-1:0]  lane_idx [4];
  logic [31:0]    wdata_lj, rdata_d, occ_d;
  logic           fifo_full, fifo_empty, pop_fire, push_ok, fifo_push, ram_we;
  logic [FCW-1:0] fifo_count;
  logic [7:0]     fifo_dout;

  assign nbytes    = size_bytes(size_q);
  assign last_a    = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
  assign is_io     = (addr_q == IO_ADDR);
  assign range_err = !is_io && (last_a >= 33'(MEM_BYTES));
  // Left-justify the write data so lane k always takes byte k from the top.
  assign wdata_lj  = wdata_q << {3'd4 - nbytes, 3'b000};
  assign occ_d     = {27'b0, 5'(fifo_count)};

  assign pop_fire  = io_ready && !fifo_empty;
  assign push_ok   = !fifo_full || pop_fire;
  assign fifo_push = (state_q == RESP) && !rw_q && is_io;
  assign ram_we    = (state_q == RESP) && !rw_q && !is_io && !range_err;

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = AW'(addr_q + 32'(k));
      if (3'(k) < nbytes) rdata_d = {rdata_d[23:0], mem_q[lane_idx[k]]};
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) mem_q[lane_idx[k]] <= wdata_lj[31-8*k -: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && m_en) begin
      rw_q    <= m_rw;
      size_q  <= m_size;
      addr_q  <= abus;
      wdata_q <= dbus_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      dbus_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m_en) begin
            state_q <= WAIT;
            wcnt_q  <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (!m_en)              state_q <= IDLE;
          else if (wcnt_q == '0)  state_q <= RESP;
          else                    wcnt_q  <= wcnt_q - 4'd1;
        end
        RESP: begin
          // An IO write parks here until the FIFO can take the byte.
          if (is_io && !rw_q) begin
            if (push_ok) begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
            if (range_err) begin
              err_q  <= 1'b1;
              dbus_q <= '0;
            end else if (is_io) begin
              dbus_q <= occ_d;
            end else if (rw_q) begin
              dbus_q <= rdata_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cpu0_io_fifo #(
    .WIDTH (8),
    .DEPTH (IO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (wdata_q[7:0]),
    .full  (fifo_full),
    .pop   (io_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign dbus_out = dbus_q;
  assign m_ready  = ready_q;
  assign m_err    = err_q;
  assign io_data  = fifo_dout;
  assign io_valid = !fifo_empty;

endmodule
